// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared encodings for the unified memory port arbiter
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_CPU  = 2'b01,
        GNT_DMA  = 2'b10
    } grant_t;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - CPU-priority winner select with DMA starvation override
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cpu_req,
    input  logic       dma_req,
    input  logic       arb_stb,
    output logic [1:0] winner,
    output logic       dma_forced
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

    logic [CW-1:0] starve_q;
    logic [CW-1:0] starve_d;
    logic [1:0]    final_gnt;

    // winner is the plain CPU-first choice; dma_forced overrides it when DMA has waited long enough
    always_comb begin
        dma_forced = cpu_req && dma_req && (starve_q == SMAX);
        if (cpu_req)
            winner = GNT_CPU;
        else if (dma_req)
            winner = GNT_DMA;
        else
            winner = GNT_NONE;
        final_gnt = dma_forced ? GNT_DMA : winner;

        starve_d = starve_q;
        if (arb_stb) begin
            if (final_gnt == GNT_DMA)
                starve_d = '0;
            else if (final_gnt == GNT_CPU && dma_req && starve_q != SMAX)
                starve_d = starve_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            starve_q <= '0;
        else
            starve_q <= starve_d;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between the CPU path and a DMA/loader master
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic [DW-1:0] dma_rdata,
    output logic          dma_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    grant,
    output logic          busy
);

    localparam int LW = $clog2(MEM_LAT + 1);

    state_t        state_q, state_d;
    logic [LW-1:0] lat_q, lat_d;
    logic [1:0]    grant_q, grant_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic          dma_ack_q, dma_ack_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] dma_rdata_q, dma_rdata_d;

    logic       arb_stb;
    logic [1:0] prio_gnt;
    logic       dma_forced;
    logic [1:0] pick_gnt;

    assign arb_stb  = (state_q == ST_IDLE) && (cpu_req || dma_req);
    assign pick_gnt = dma_forced ? GNT_DMA : prio_gnt;

    mem_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .clk        (clk),
        .rst_n      (rst),
        .cpu_req    (cpu_req),
        .dma_req    (dma_req),
        .arb_stb    (arb_stb),
        .winner     (prio_gnt),
        .dma_forced (dma_forced)
    );

    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        grant_d     = grant_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_ack_d   = 1'b0;
        dma_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (arb_stb) begin
                    grant_d  = pick_gnt;
                    mem_en_d = 1'b1;
                    if (pick_gnt == GNT_DMA) begin
                        mem_we_d    = dma_we;
                        mem_addr_d  = dma_addr;
                        mem_wdata_d = dma_wdata;
                    end else begin
                        mem_we_d    = cpu_we;
                        mem_addr_d  = cpu_addr;
                        mem_wdata_d = cpu_wdata;
                    end
                    state_d = ST_ISSUE;
                end
            end
            // mem_we_q still holds the latched direction during the issue cycle
            ST_ISSUE: begin
                if (mem_we_q) begin
                    state_d   = ST_DONE;
                    cpu_ack_d = (grant_q == GNT_CPU);
                    dma_ack_d = (grant_q == GNT_DMA);
                end else begin
                    state_d = ST_WAIT;
                    lat_d   = LW'(MEM_LAT);
                end
            end
            ST_WAIT: begin
                lat_d = lat_q - LW'(1);
                if (lat_q == LW'(1)) begin
                    if (grant_q == GNT_DMA) begin
                        dma_rdata_d = mem_rdata;
                        dma_ack_d   = 1'b1;
                    end else begin
                        cpu_rdata_d = mem_rdata;
                        cpu_ack_d   = 1'b1;
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                grant_d = GNT_NONE;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            lat_q       <= '0;
            grant_q     <= GNT_NONE;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            grant_q     <= grant_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_ack_q   <= cpu_ack_d;
            dma_ack_q   <= dma_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign dma_ack   = dma_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;
    assign grant     = grant_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int LAT  = 2;
    localparam int SMAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, cpu_ack;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        dma_req, dma_we, dma_ack;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic        mem_en, mem_we, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  grant;

    logic        c1_req, c1_ack, d1_ack, m1_en, m1_we, b1;
    logic [31:0] c1_addr, c1_rdata, d1_rdata, m1_addr, m1_wdata, m1_rdata;
    logic [1:0]  g1;

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .grant(grant), .busy(busy)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .STARVE_MAX(SMAX)) dut1 (
        .clk(clk), .rst(rst),
        .cpu_req(c1_req), .cpu_we(1'b0), .cpu_addr(c1_addr), .cpu_wdata(32'h0),
        .cpu_rdata(c1_rdata), .cpu_ack(c1_ack),
        .dma_req(1'b0), .dma_we(1'b0), .dma_addr(32'h0), .dma_wdata(32'h0),
        .dma_rdata(d1_rdata), .dma_ack(d1_ack),
        .mem_en(m1_en), .mem_we(m1_we), .mem_addr(m1_addr), .mem_wdata(m1_wdata),
        .mem_rdata(m1_rdata), .grant(g1), .busy(b1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory environment: data is presented only in the single cycle MEM_LAT after mem_en
    logic [31:0] env_mem [64];
    logic [31:0] ref_mem [64];
    int          pend_cnt = 0;
    logic [31:0] pend_data;
    always @(negedge clk) begin
        if (pend_cnt > 0) pend_cnt--;
        if (rst && mem_en) begin
            if (mem_we) env_mem[mem_addr[7:2]] = mem_wdata;
            else begin
                pend_data = env_mem[mem_addr[7:2]];
                pend_cnt  = LAT + 1;
            end
        end
        mem_rdata = (pend_cnt == 1) ? pend_data : 32'hBAD0_BAD0;
    end

    int p1 = 0;
    always @(negedge clk) begin
        if (p1 > 0) p1--;
        if (rst && m1_en && !m1_we) p1 = 2;
        m1_rdata = (p1 == 1) ? 32'h600D_0001 : 32'hBAD0_BAD0;
    end

    // Transaction-level model: a sample at cycle s owns the port until s+2 (write) or s+2+LAT (read)
    bit          m_act = 0;
    int          m_start, m_end, m_starve = 0;
    logic [1:0]  m_win;
    logic        m_we;
    logic [31:0] m_addr, m_wdata, m_rd;
    logic [31:0] e_crd = 0, e_drd = 0;
    logic        e_busy, e_en, e_cack, e_dack;
    logic [1:0]  e_grant;

    always @(negedge clk) begin
        if (!rst) begin
            m_act = 0; m_starve = 0; e_crd = 0; e_drd = 0;
            e_busy = 0; e_en = 0; e_cack = 0; e_dack = 0; e_grant = 0;
        end else begin
            if (m_act && cyc > m_end) m_act = 0;
            if (!m_act && (cpu_req || dma_req)) begin
                m_win = (dma_req && (!cpu_req || m_starve == SMAX)) ? 2'b10 : 2'b01;
                if (m_win == 2'b10) m_starve = 0;
                else if (dma_req && m_starve < SMAX) m_starve++;
                m_we    = (m_win == 2'b10) ? dma_we    : cpu_we;
                m_addr  = (m_win == 2'b10) ? dma_addr  : cpu_addr;
                m_wdata = (m_win == 2'b10) ? dma_wdata : cpu_wdata;
                if (m_we) ref_mem[m_addr[7:2]] = m_wdata;
                m_rd    = ref_mem[m_addr[7:2]];
                m_act   = 1; m_start = cyc;
                m_end   = cyc + 2 + (m_we ? 0 : LAT);
            end
            e_busy  = m_act && cyc > m_start;
            e_grant = e_busy ? m_win : 2'b00;
            e_en    = m_act && cyc == m_start + 1;
            e_cack  = m_act && cyc == m_end && m_win == 2'b01;
            e_dack  = m_act && cyc == m_end && m_win == 2'b10;
            if (e_cack && !m_we) e_crd = m_rd;
            if (e_dack && !m_we) e_drd = m_rd;
        end
        chk("busy",      32'(busy),    32'(e_busy));
        chk("grant",     32'(grant),   32'(e_grant));
        chk("mem_en",    32'(mem_en),  32'(e_en));
        chk("mem_we",    32'(mem_we),  32'(e_en && m_we));
        chk("cpu_ack",   32'(cpu_ack), 32'(e_cack));
        chk("dma_ack",   32'(dma_ack), 32'(e_dack));
        chk("cpu_rdata", cpu_rdata,    e_crd);
        chk("dma_rdata", dma_rdata,    e_drd);
        if (e_en) begin
            chk("mem_addr", mem_addr, m_addr);
            if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
        end
    end

    task automatic access(input bit is_dma, input bit we, input logic [31:0] a,
                          input logic [31:0] wd, input bit hold,
                          output int en_abs, output int ack_off, output int en_n,
                          output logic [31:0] rd);
        int c0;
        c0 = cyc;
        en_abs = -1; ack_off = -1; en_n = 0; rd = 32'h0;
        if (is_dma) begin
            dma_req = 1; dma_we = we; dma_addr = a; dma_wdata = wd;
        end else begin
            cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_en) begin
                en_n++;
                if (en_abs < 0) en_abs = cyc;
            end
            if (is_dma ? dma_ack : cpu_ack) begin
                ack_off = cyc - c0;
                rd = is_dma ? dma_rdata : cpu_rdata;
                break;
            end
        end
        chk("ack_seen", 32'(ack_off >= 0), 32'd1);
        @(posedge clk); #1;
        if (!hold) begin
            if (is_dma) dma_req = 0; else cpu_req = 0;
        end
        en_abs = en_abs - c0;
    endtask

    int          en_o, ack_o, en_n, en_a, n;
    logic [31:0] rd;
    logic [1:0]  order [10];
    logic [1:0]  exp_order [10];

    initial begin
        rst = 0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
        c1_req = 0; c1_addr = 0;
        mem_rdata = 32'hBAD0_BAD0; m1_rdata = 32'hBAD0_BAD0;
        for (int i = 0; i < 64; i++) begin
            env_mem[i] = 32'hC0DE_0000 | 32'(i);
            ref_mem[i] = 32'hC0DE_0000 | 32'(i);
        end
        env_mem[8] = 32'hDEAD_BEEF; ref_mem[8] = 32'hDEAD_BEEF;
        for (int i = 0; i < 10; i++) order[i] = 2'b00;
        exp_order = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};

        repeat (3) @(posedge clk); #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_mem_en", 32'(mem_en), 0);
        rst = 1;
        @(posedge clk); #1;

        // abort a read while it waits on memory
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h30;
        @(posedge clk); @(posedge clk); #3;
        chk("pre_abort_grant", 32'(grant), 32'd1);
        rst = 0;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_grant", 32'(grant), 0);
        chk("abort_mem_en", 32'(mem_en), 0);
        cpu_req = 0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1;
        repeat (4) @(posedge clk); #1;

        access(0, 0, 32'h10, 32'h0, 0, en_o, ack_o, en_n, rd);
        chk("post_rst_ack_off", 32'(ack_o), 32'd4);
        chk("post_rst_rdata", rd, 32'hC0DE_0004);

        access(0, 0, 32'h20, 32'h0, 0, en_o, ack_o, en_n, rd);
        chk("rd_en_off", 32'(en_o), 32'd1);
        chk("rd_en_count", 32'(en_n), 32'd1);
        chk("rd_ack_off", 32'(ack_o), 32'd4);
        chk("rd_rdata", rd, 32'hDEAD_BEEF);

        access(1, 1, 32'h40, 32'h1234_5678, 0, en_o, ack_o, en_n, rd);
        chk("wr_en_off", 32'(en_o), 32'd1);
        chk("wr_ack_off", 32'(ack_o), 32'd2);
        chk("wr_mem_content", env_mem[16], 32'h1234_5678);
        chk("cpu_rdata_held", cpu_rdata, 32'hDEAD_BEEF);

        access(0, 0, 32'h0, 32'h0, 1, en_a, ack_o, en_n, rd);
        en_a = en_a + cyc - 5;
        chk("b2b_first_rdata", rd, 32'hC0DE_0000);
        access(0, 0, 32'h4, 32'h0, 0, en_o, ack_o, en_n, rd);
        en_o = en_o + cyc - 5;
        chk("b2b_second_rdata", rd, 32'hC0DE_0001);
        chk("b2b_en_gap", 32'(en_o - en_a), 32'd5);

        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h8;
        dma_req = 1; dma_we = 1; dma_addr = 32'h80; dma_wdata = 32'h5A5A_5A5A;
        n = 0;
        for (int i = 0; i < 200 && n < 10; i++) begin
            @(negedge clk);
            if (cpu_ack) begin order[n] = 2'b01; n++; end
            else if (dma_ack) begin order[n] = 2'b10; n++; end
        end
        @(posedge clk); #1;
        cpu_req = 0; dma_req = 0;
        for (int i = 0; i < 10; i++) chk($sformatf("starve_order_%0d", i), 32'(order[i]), 32'(exp_order[i]));

        repeat (2) @(posedge clk); #1;
        c1_req = 1; c1_addr = 32'h24;
        n = cyc; en_o = -1; ack_o = -1; rd = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (m1_en && en_o < 0) begin
                en_o = cyc - n;
                chk("lat1_addr", m1_addr, 32'h24);
            end
            if (c1_ack) begin
                ack_o = cyc - n; rd = c1_rdata;
                chk("lat1_grant", 32'(g1), 32'd1);
                break;
            end
        end
        @(posedge clk); #1;
        c1_req = 0;
        chk("lat1_en_off", 32'(en_o), 32'd1);
        chk("lat1_ack_off", 32'(ack_o), 32'd3);
        chk("lat1_rdata", rd, 32'h600D_0001);
        repeat (3) @(posedge clk); #1;
        chk("lat1_idle", 32'({b1, d1_ack}), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory port between the multicycle CPU controller path and a DMA/loader master.
- The CPU path is the IorD-muxed address/write path; the DMA/loader master fills memory at boot and moves I/O blocks.
- Sequences each access through issue, fixed-latency wait and completion, and returns a one-cycle ack to the winning requester.
- CPU has priority; a starvation counter guarantees DMA forward progress.

Parameters:
AW, 32, address width
DW, 32, data width
MEM_LAT, 2, read latency of memory in cycles (>=1): mem_rdata is valid MEM_LAT cycles after the mem_en cycle
STARVE_MAX, 4, number of consecutive CPU wins over a pending DMA request before DMA is forced

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
cpu_req  in  1  CPU access request, held until cpu_ack
cpu_we  in  1  CPU write (1) / read (0)
cpu_addr  in  AW  CPU byte address
cpu_wdata  in  DW  CPU write data
cpu_rdata  out  DW  CPU read data, valid with cpu_ack, held until next CPU read completes
cpu_ack  out  1  one-cycle completion pulse
dma_req, dma_we, dma_addr, dma_wdata, dma_rdata, dma_ack  same as CPU set, DMA side
mem_en  out  1  memory access strobe, one cycle per access
mem_we  out  1  memory write enable, only with mem_en
mem_addr  out  AW  latched address
mem_wdata  out  DW  latched write data
mem_rdata  in  DW  memory read data
grant  out  2  00 none, 01 CPU, 10 DMA; owner of the current transaction
busy  out  1  state != IDLE

Behaviour:
- Reset (rst=0, asynchronous):
  - State IDLE.
  - All outputs 0: mem_en, mem_we, mem_addr, mem_wdata, cpu_ack, dma_ack, cpu_rdata, dma_rdata, grant, busy.
  - Starvation counter 0.
  - Reset mid-transaction aborts it: mem_en/mem_we drop immediately and no ack is issued.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any req is high, select a winner, latch its we/addr/wdata into the mem_* registers, set grant, go to ISSUE.
  - Otherwise stay in IDLE.
- Arbitration:
  - Only cpu_req → CPU. Only dma_req → DMA.
  - Both high → DMA if starve_cnt == STARVE_MAX, else CPU.
  - starve_cnt increments (saturating at STARVE_MAX) on each CPU win while dma_req=1.
  - starve_cnt clears on any DMA grant.
- ISSUE:
  - mem_en=1 for exactly this cycle; mem_we = latched we.
  - Write → DONE. Read → WAIT with lat_cnt = MEM_LAT.
- WAIT:
  - Decrement lat_cnt each cycle.
  - In the cycle lat_cnt==1, capture mem_rdata into the granted requester's rdata register, then go to DONE.
- DONE:
  - Pulse the granted requester's ack for one cycle, clear grant, go to IDLE.
  - The other requester's ack and rdata are untouched.
- Latency, with request sampled in cycle c:
  - Write: mem_en at c+1, ack at c+2.
  - Read: mem_en at c+1, data captured at c+1+MEM_LAT, ack at c+2+MEM_LAT.
- Handshake rules:
  - The requester holds req, we, addr and wdata stable until ack.
  - req still high in the cycle after ack counts as a new request (back-to-back accesses allowed; minimum one IDLE cycle between transactions).
  - Requester inputs changing after the IDLE sample have no effect on the current transaction.
  - A req dropped before ack is ignored; the transaction still completes and acks.
- The memory never sees two mem_en pulses per transaction, and never sees mem_en outside ISSUE.

Decomposition:
- Shared encode-def header holds:
  - FSM state encodings (IDLE 2'b00, ISSUE 2'b01, WAIT 2'b10, DONE 2'b11).
  - Grant encodings (GNT_NONE, GNT_CPU, GNT_DMA).
- Sub-module mem_arb_pick:
  - Combinational winner select plus the registered starvation counter.
  - Inputs: cpu_req, dma_req, an arbitration strobe.
  - Outputs: winner, the DMA-forced flag.
- The top level holds the FSM, latency counter and data latches.

Test Plan:
- Reset: hold rst=0 mid-read (state WAIT, MEM_LAT=2) → all outputs 0 immediately, no ack afterwards; after release, a CPU read of addr 0x10 acks 4 cycles after sampling.
- Single CPU read at 0x20 with memory model returning 0xDEADBEEF, MEM_LAT=2 → mem_en exactly one cycle at c+1, cpu_ack at c+4, cpu_rdata=0xDEADBEEF held afterwards.
- DMA write at 0x40 data 0x12345678 → mem_we=1 with mem_en at c+1, dma_ack at c+2, cpu_ack stays 0, grant=10 during the transaction.
- Simultaneous cpu_req and dma_req held continuously, STARVE_MAX=4 → grant order CPU, CPU, CPU, CPU, DMA, then CPU resumes; starve_cnt returns to 0.
- Back-to-back CPU reads with req held high through ack at addresses 0x0 then 0x4 → two distinct mem_en pulses separated by the DONE and IDLE cycles; each ack carries its own data.
- MEM_LAT=1 build: read acks at c+3 and data is captured in the cycle after mem_en.
